// File: rtl/st7735_spi_sink.sv
// Panel-side ST7735 4-wire SPI receiver: oversamples the link, decodes CASET/RASET/RAMWR and
// emits one (x, y, RGB565) pixel per RAMWR pixel. Define ST7735_SINK_STATS_EN for frame stats.
module st7735_spi_sink #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           oled_cs,
  input  logic           oled_clk,
  input  logic           oled_mosi,
  input  logic           oled_dc,
  output logic           cmd_valid,
  output logic [7:0]     cmd_byte,
  output logic           pix_valid,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic [15:0]    pix_color
`ifdef ST7735_SINK_STATS_EN
  ,
  output logic           frame_done,
  output logic [31:0]    pix_count
`endif
);

  typedef enum logic [2:0] {StCmd, StCaset, StRaset, StRamwr, StSkip} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, ck_sync_q, mo_sync_q, dc_sync_q;
  logic                   cs_s, ck_s, mo_s, dc_s, ck_prev_q, ck_rise;
  logic [2:0]             bitcnt_q;
  logic [7:0]             sr_q;
  logic                   dc_lat_q, byte_done_q;

  state_e state_q, state_d;
  logic [1:0]     argcnt_q, argcnt_d;
  logic [X_W-1:0] xs_q, xs_d, xe_q, xe_d, cx_q, cx_d, pix_x_q, pix_x_d;
  logic [Y_W-1:0] ys_q, ys_d, ye_q, ye_d, cy_q, cy_d, pix_y_q, pix_y_d;
  logic           phase_q, phase_d, cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d;
  logic [7:0]     hi_q, hi_d, cmd_byte_q, cmd_byte_d;
  logic [15:0]    pix_color_q, pix_color_d;
`ifdef ST7735_SINK_STATS_EN
  logic           frame_done_q, frame_done_d;
  logic [31:0]    pix_count_q, pix_count_d;
`endif

  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign ck_s    = ck_sync_q[SYNC_STAGES-1];
  assign mo_s    = mo_sync_q[SYNC_STAGES-1];
  assign dc_s    = dc_sync_q[SYNC_STAGES-1];
  assign ck_rise = ck_s & ~ck_prev_q;

  // cs resets high so no spurious shift happens right after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_q <= '1;
      ck_sync_q <= '0;
      mo_sync_q <= '0;
      dc_sync_q <= '0;
      ck_prev_q <= 1'b0;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], oled_cs};
      ck_sync_q <= {ck_sync_q[SYNC_STAGES-2:0], oled_clk};
      mo_sync_q <= {mo_sync_q[SYNC_STAGES-2:0], oled_mosi};
      dc_sync_q <= {dc_sync_q[SYNC_STAGES-2:0], oled_dc};
      ck_prev_q <= ck_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitcnt_q    <= '0;
      sr_q        <= '0;
      dc_lat_q    <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      byte_done_q <= ~cs_s & ck_rise & (bitcnt_q == 3'd7);
      if (cs_s) begin
        bitcnt_q <= '0;
      end else if (ck_rise) begin
        sr_q     <= {sr_q[6:0], mo_s};
        bitcnt_q <= bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd0) dc_lat_q <= dc_s;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StCmd;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (byte_done_q) begin
      if (!dc_lat_q) begin
        case (sr_q)
          8'h2A:   state_d = StCaset;
          8'h2B:   state_d = StRaset;
          8'h2C:   state_d = StRamwr;
          default: state_d = StSkip;
        endcase
      end else if ((state_q == StCaset || state_q == StRaset) && argcnt_q == 2'd3) begin
        state_d = StSkip;
      end
    end
  end

  always_comb begin
    argcnt_d    = argcnt_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    cmd_byte_d  = cmd_byte_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    cmd_valid_d = 1'b0;
    pix_valid_d = 1'b0;
`ifdef ST7735_SINK_STATS_EN
    frame_done_d = 1'b0;
    pix_count_d  = pix_count_q;
`endif
    if (byte_done_q) begin
      if (!dc_lat_q) begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = sr_q;
        case (sr_q)
          8'h2A, 8'h2B: argcnt_d = '0;
          8'h2C: begin
            cx_d    = xs_q;
            cy_d    = ys_q;
            phase_d = 1'b0;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          StCaset: begin
            if (argcnt_q == 2'd1) xs_d = sr_q[X_W-1:0];
            if (argcnt_q == 2'd3) xe_d = sr_q[X_W-1:0];
            argcnt_d = argcnt_q + 2'd1;
          end
          StRaset: begin
            if (argcnt_q == 2'd1) ys_d = sr_q[Y_W-1:0];
            if (argcnt_q == 2'd3) ye_d = sr_q[Y_W-1:0];
            argcnt_d = argcnt_q + 2'd1;
          end
          StRamwr: begin
            if (!phase_q) begin
              hi_d    = sr_q;
              phase_d = 1'b1;
            end else begin
              phase_d     = 1'b0;
              pix_valid_d = 1'b1;
              pix_x_d     = cx_q;
              pix_y_d     = cy_q;
              pix_color_d = {hi_q, sr_q};
`ifdef ST7735_SINK_STATS_EN
              frame_done_d = (cx_q == xe_q) && (cy_q == ye_q);
              pix_count_d  = pix_count_q + 32'd1;
`endif
              // Equality-only wrap: a degenerate window counts modulo 2^W until it hits xe/ye.
              if (cx_q == xe_q) begin
                cx_d = xs_q;
                cy_d = (cy_q == ye_q) ? ys_q : cy_q + Y_W'(1);
              end else begin
                cx_d = cx_q + X_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      argcnt_q    <= '0;
      xs_q        <= '0;
      xe_q        <= '1;
      ys_q        <= '0;
      ye_q        <= '1;
      cx_q        <= '0;
      cy_q        <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
`ifdef ST7735_SINK_STATS_EN
      frame_done_q <= 1'b0;
      pix_count_q  <= '0;
`endif
    end else begin
      argcnt_q    <= argcnt_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
`ifdef ST7735_SINK_STATS_EN
      frame_done_q <= frame_done_d;
      pix_count_q  <= pix_count_d;
`endif
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
`ifdef ST7735_SINK_STATS_EN
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;
`endif

endmodule

// File: tb/tb_st7735_spi_sink.sv
// Scoreboard bench for st7735_spi_sink: stimulus pushes expected commands/pixels, a monitor
// pops and compares on every cmd_valid/pix_valid pulse.
module tb_st7735_spi_sink;

  logic        clk, reset;
  logic        oled_cs, oled_clk, oled_mosi, oled_dc;
  logic        cmd_valid, pix_valid;
  logic [7:0]  cmd_byte;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [15:0] pix_color;
`ifdef ST7735_SINK_STATS_EN
  logic        frame_done;
  logic [31:0] pix_count;
`endif

  st7735_spi_sink dut (
    .clk       (clk),
    .reset     (reset),
    .oled_cs   (oled_cs),
    .oled_clk  (oled_clk),
    .oled_mosi (oled_mosi),
    .oled_dc   (oled_dc),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color)
`ifdef ST7735_SINK_STATS_EN
    ,
    .frame_done(frame_done),
    .pix_count (pix_count)
`endif
  );

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [15:0] c;
    logic        fd;
  } pix_t;

  logic [7:0] exp_cmd[$];
  pix_t       exp_pix[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last8_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each output pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid && pix_valid) begin
        miscompares++;
        $display("FAIL both_valid: cmd_valid and pix_valid high together at %0t", $time);
      end
      if (cmd_valid) begin
        chk("cmd_expected", 32'(exp_cmd.size() > 0), 32'd1);
        if (exp_cmd.size() > 0) chk("cmd_byte", 32'(cmd_byte), 32'(exp_cmd.pop_front()));
        chk("cmd_latency", 32'(cyc - last8_cyc), 32'd4);
      end
      if (pix_valid) begin
        chk("pix_expected", 32'(exp_pix.size() > 0), 32'd1);
        if (exp_pix.size() > 0) begin
          pix_t e;
          e = exp_pix.pop_front();
          chk("pix_x", 32'(pix_x), 32'(e.x));
          chk("pix_y", 32'(pix_y), 32'(e.y));
          chk("pix_color", 32'(pix_color), 32'(e.c));
`ifdef ST7735_SINK_STATS_EN
          chk("frame_done", 32'(frame_done), 32'(e.fd));
`endif
        end
      end
    end
  end

  task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
    oled_cs = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      oled_dc   = dc;
      oled_mosi = b[i];
      #40 oled_clk = 1'b1;
      if (i == 0) last8_cyc = cyc;
      #40 oled_clk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    exp_cmd.push_back(b);
    send_bits(1'b0, b, 8);
  endtask

  task automatic send_data(input logic [7:0] b);
    send_bits(1'b1, b, 8);
  endtask

  task automatic send_pix(input logic [15:0] c, input logic [7:0] x, input logic [6:0] y,
                          input logic fd);
    pix_t p;
    p.x = x; p.y = y; p.c = c; p.fd = fd;
    exp_pix.push_back(p);
    send_data(c[15:8]);
    send_data(c[7:0]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_cmd_byte"},  32'(cmd_byte),  32'd0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_pix_x"},     32'(pix_x),     32'd0);
    chk({tag, "_pix_y"},     32'(pix_y),     32'd0);
    chk({tag, "_pix_color"}, 32'(pix_color), 32'd0);
`ifdef ST7735_SINK_STATS_EN
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_pix_count"},  pix_count,       32'd0);
`endif
  endtask

  logic [7:0]  xs_tab [6];
  logic [6:0]  ys_tab [6];

  initial begin
    reset = 1'b1; oled_cs = 1'b1; oled_clk = 1'b0; oled_mosi = 1'b0; oled_dc = 1'b0;
    repeat (4) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_zero("post_reset");

    // 1: RAMWR with full default window -> pixel at origin.
    send_cmd(8'h2C);
    send_pix(16'hF800, 8'd0, 7'd0, 1'b0);

    // 2: 3x2 window at (2..4, 1..2), six pixels plus one wrap.
    send_cmd(8'h2A);
    send_data(8'h00); send_data(8'h02); send_data(8'h00); send_data(8'h04);
    send_cmd(8'h2B);
    send_data(8'h00); send_data(8'h01); send_data(8'h00); send_data(8'h02);
    send_cmd(8'h2C);
    xs_tab = '{8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4};
    ys_tab = '{7'd1, 7'd1, 7'd1, 7'd2, 7'd2, 7'd2};
    for (int i = 0; i < 6; i++) send_pix(16'h07E0, xs_tab[i], ys_tab[i], i == 5);
    send_pix(16'h07E0, 8'd2, 7'd1, 1'b0);

    // 3: half pixel aborted by a new RAMWR.
    send_cmd(8'h2C);
    send_data(8'hAB);
    send_cmd(8'h2C);
    send_pix(16'h001F, 8'd2, 7'd1, 1'b0);

    // 4: partial byte dropped by cs high.
    send_bits(1'b0, 8'hFF, 5);
    #40 oled_cs = 1'b1;
    #160;
    send_cmd(8'h2A);

    // 5: unknown command then data; window must survive.
    send_cmd(8'h11);
    send_data(8'h01); send_data(8'h02); send_data(8'h03);
    send_cmd(8'h2C);
    send_pix(16'h1234, 8'd2, 7'd1, 1'b0);
    repeat (10) @(negedge clk);
`ifdef ST7735_SINK_STATS_EN
    chk("pix_count_before_reset", pix_count, 32'd10);
`endif

    // 6: reset during second byte of a pixel.
    send_cmd(8'h2C);
    send_data(8'hFF);
    send_bits(1'b1, 8'hFF, 4);
    #20 reset = 1'b1;
    #1;
    check_zero("mid_reset");
    oled_cs = 1'b1; oled_clk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_data(8'hFF); send_data(8'hFF);
    send_cmd(8'h2C);
    send_pix(16'hABCD, 8'd0, 7'd0, 1'b0);
    #40 oled_cs = 1'b1;

    repeat (20) @(negedge clk);
`ifdef ST7735_SINK_STATS_EN
    chk("pix_count_final", pix_count, 32'd1);
`endif
    chk("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
    chk("pix_queue_drained", 32'(exp_pix.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
